// File: rtl/ssd_scan_mux.sv
`default_nettype none
// ============================================================================
// ssd_scan_mux : time-multiplexed seven-segment scan driver with a
//                frame-synchronous double-buffered BCD value and LZ blanking
// Revision     : 1.0
// ============================================================================
module ssd_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [4*NUM_DIGITS-1:0]         value_in,
    input  logic                            load,
    input  logic                            blank_lz,
    output logic [NUM_DIGITS-1:0]           anode_o,
    output logic [3:0]                      display_o,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx_o,
    output logic                            tick_o,
    output logic                            frame_o
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] c_PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]            presc_q, presc_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]  pending_q;
    logic                     pending_valid_q;
    logic [4*NUM_DIGITS-1:0]  shadow_q;
    logic                     adv_q, wrap_q;

    logic [NUM_DIGITS-1:0]    anode_q;
    logic [3:0]               display_q;
    logic [IW-1:0]            digit_idx_q;
    logic                     tick_q, frame_q;

    logic                     w_tc, w_wrap;
    logic                     w_zero_run;
    logic [NUM_DIGITS-1:0]    w_blank_mask;
    logic [NUM_DIGITS-1:0]    w_sel;
    logic [3:0]               w_digit;

    assign w_tc   = (presc_q == c_PRESC_TC);
    assign w_wrap = w_tc && (idx_q == c_IDX_LAST);

    always_comb begin
        presc_d = w_tc ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (w_tc) begin
            idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Walk from the most significant digit down; a digit is blanked while
    // every digit from it upward is zero. Digit 0 always stays lit.
    always_comb begin
        w_zero_run   = 1'b1;
        w_blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run & (shadow_q[4*i +: 4] == 4'h0);
            w_blank_mask[i] = blank_lz & w_zero_run & (i != 0);
        end
    end

    assign w_sel   = NUM_DIGITS'(1) << idx_q;
    assign w_digit = shadow_q[{idx_q, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q         <= '0;
            idx_q           <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            shadow_q        <= '0;
            adv_q           <= 1'b0;
            wrap_q          <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            adv_q   <= w_tc;
            wrap_q  <= w_wrap;
            // A load on the wrap edge goes straight to the display and
            // supersedes whatever was still pending.
            if (w_wrap) begin
                if (load) begin
                    shadow_q <= value_in;
                end else if (pending_valid_q) begin
                    shadow_q <= pending_q;
                end
                pending_valid_q <= 1'b0;
            end else if (load) begin
                pending_q       <= value_in;
                pending_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q     <= '1;
            display_q   <= 4'hF;
            digit_idx_q <= '0;
            tick_q      <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            digit_idx_q <= idx_q;
            tick_q      <= adv_q;
            frame_q     <= wrap_q;
            if (w_blank_mask[idx_q]) begin
                anode_q   <= '1;
                display_q <= 4'hF;
            end else begin
                anode_q   <= ~w_sel;
                display_q <= w_digit;
            end
        end
    end

    assign anode_o     = anode_q;
    assign display_o   = display_q;
    assign digit_idx_o = digit_idx_q;
    assign tick_o      = tick_q;
    assign frame_o     = frame_q;

endmodule
`default_nettype wire

// File: doc/ssd_scan_mux.md
# ssd_scan_mux

Time-multiplexed scan driver for the board's multi-digit seven-segment display. Holds a packed BCD value, cycles through the digits at a fixed refresh rate, and for each digit drives the active-low anode enable plus the 4-bit BCD nibble consumed by the downstream BCD-to-segment decoder. New values are double-buffered and applied only at frame boundaries, so a display never shows a mix of old and new digits. Optional leading-zero blanking is supported.

## Interface
- NUM_DIGITS, 4: number of digits scanned (2..8).
- REFRESH_DIV, 100000: clock cycles each digit stays active (>= 2).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- value_in  in  4*NUM_DIGITS  packed BCD value; digit 0 (rightmost) = value_in[3:0].
- load  in  1  one-cycle strobe; captures value_in into the pending buffer.
- blank_lz  in  1  1 = blank leading zeros (digit 0 is never blanked).
- anode_o  out  NUM_DIGITS  active-low digit enables; at most one bit low.
- display_o  out  4  BCD nibble for the segment decoder; 4'hF when blanked or idle.
- digit_idx_o  out  clog2(NUM_DIGITS)  index of the currently driven digit.
- tick_o  out  1  one-cycle pulse when the scan index advances.
- frame_o  out  1  one-cycle pulse when the index wraps NUM_DIGITS-1 -> 0.

## Operation
- Prescaler counts 0..REFRESH_DIV-1, wraps to 0; at terminal count (REFRESH_DIV-1) the scan index advances by 1, wrapping NUM_DIGITS-1 -> 0.
- Two value registers: pending (+ pending_valid flag) and shadow (displayed).
- load=1: pending <= value_in, pending_valid <= 1. Repeated loads before a frame boundary overwrite pending (last wins).
- At index wrap to 0: if pending_valid, shadow <= pending, pending_valid <= 0.
- load coincident with wrap: value_in bypasses directly into shadow, pending_valid <= 0; any older pending value is discarded.
- Digit i is blanked when blank_lz=1, i != 0, and shadow digits i..NUM_DIGITS-1 are all 4'h0.
- Per cycle, outputs registered from current index and shadow: non-blanked digit -> anode_o = ~(1 << idx), display_o = shadow digit idx; blanked -> anode_o all ones, display_o = 4'hF.
- Nibbles > 9 pass through unchanged (decoder blanks them); no range check here.
- digit_idx_o mirrors the registered index used for anode_o/display_o.

## Timing
- Reset (synchronous, wins over everything): prescaler 0, index 0, pending 0, pending_valid 0, shadow 0; anode_o all ones, display_o 4'hF, digit_idx_o 0, tick_o 0, frame_o 0.
- First edge after reset deasserts: outputs show digit 0 of shadow (value 0 -> display_o 4'h0, anode_o bit0 low).
- Outputs lag internal index by exactly one cycle; tick_o/frame_o assert in the same cycle the new anode_o/display_o appear.
- Each digit active exactly REFRESH_DIV cycles; frame = NUM_DIGITS*REFRESH_DIV cycles; frame_o period equals frame length.
- load to visible change: at most one frame + 1 cycle; earliest is the first cycle of the next frame (digit 0).
- blank_lz and shadow changes take effect on the next registered output update (1 cycle).
- Reset asserted mid-frame: discards pending load, outputs return to reset values on that edge; scan restarts at digit 0 with a full REFRESH_DIV dwell.
- anode_o never has two bits low in any cycle, including across index transitions.

## Test plan
- Reset: hold reset 3 cycles with load=1 -> anode_o=4'b1111, display_o=4'hF, tick_o=frame_o=0; after release shadow=0, digit 0 shows 4'h0.
- Scan, REFRESH_DIV=4, value 16'h1234 loaded then one frame elapsed -> display_o sequence 4,3,2,1 each for 4 cycles, anode_o 1110,1101,1011,0111; tick_o every 4 cycles, frame_o every 16.
- Double buffer: shadow 16'h1234, load 16'h5678 while digit 2 active -> digits 2,3 still show 2,1; next frame shows 8,7,6,5.
- Last-wins + coincident: load 16'h1111 then 16'h2222 mid-frame -> next frame shows 2222; load 16'h9999 on the wrap cycle -> that frame shows 9999.
- Blanking: blank_lz=1, value 16'h0040 -> digit 0 shows 0, digit 1 shows 4, digits 2,3 anode high, display_o 4'hF; value 16'h0000 -> only digit 0 lit showing 0; blank_lz=0 -> all four digits lit.
- Reset mid-frame with pending load -> pending discarded, after release shadow=0 and scan restarts at digit 0 with full 4-cycle dwell.
